flag_branch_unit: RTL and testbench

- Execute-stage consumer of the ALU outputs in core_lapido.
- Holds the architectural condition flags: the five ALU flags plus the carry, which the ALU delivers in bit 32 of its result.
- Resolves conditional jumps (jump-if-true / jump-if-false on a selected flag) for the branch in ID, forwarding same-cycle ALU flags.
- Handles pipeline stall and flush, and reports resolution to fetch/hazard control.

---
 rtl/flag_branch_unit.sv | 101 ++++++++++
 tb/tb_flag_branch_unit.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/flag_branch_unit.sv
// Execute-stage condition flag register and conditional-branch resolver.
// Forwards same-cycle ALU flags into the decision and holds a branch across stalls.
module flag_branch_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int FLAG_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall,
    input  logic                  flush,
    input  logic [DATA_WIDTH:0]   alu_res,
    input  logic [FLAG_WIDTH-1:0] flags,
    input  logic                  flag_we,
    input  logic                  br_valid,
    input  logic                  br_polarity,
    input  logic [2:0]            br_cond,
    output logic [FLAG_WIDTH:0]   flags_q,
    output logic                  br_resolved,
    output logic                  br_taken
);

    localparam int FL_ZERO     = 0;
    localparam int FL_TRUE     = 1;
    localparam int FL_NEG      = 2;
    localparam int FL_OVERFLOW = 3;
    localparam int FL_NEGZERO  = 4;
    localparam int FL_CARRY    = FLAG_WIDTH;

    typedef enum logic {IDLE, HOLD} state_t;

    state_t              state;
    logic [2:0]          cond_q;
    logic                pol_q;
    logic [FLAG_WIDTH:0] eff;
    logic [2:0]          cond_sel;
    logic                pol_sel;
    logic                taken_c;

    // Codes above the carry index are reserved and never take the branch.
    function automatic logic eval_cond(input logic [FLAG_WIDTH:0] f,
                                       input logic [2:0] cond,
                                       input logic pol);
        logic sel;
        sel = 1'b0;
        for (int i = 0; i <= FL_CARRY; i++) begin
            if (int'(cond) == i) sel = f[i];
        end
        if (int'(cond) > FL_CARRY) return 1'b0;
        return sel == pol;
    endfunction

    always_comb begin
        eff = flags_q;
        if (flag_we && !flush) eff = {alu_res[DATA_WIDTH], flags};
        cond_sel = (state == HOLD) ? cond_q : br_cond;
        pol_sel  = (state == HOLD) ? pol_q  : br_polarity;
        taken_c  = eval_cond(eff, cond_sel, pol_sel);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            flags_q     <= '0;
            br_resolved <= 1'b0;
            br_taken    <= 1'b0;
            state       <= IDLE;
            cond_q      <= '0;
            pol_q       <= 1'b0;
        end else begin
            br_resolved <= 1'b0;
            br_taken    <= 1'b0;
            if (flag_we && !stall && !flush)
                flags_q <= {alu_res[DATA_WIDTH], flags};
            if (flush) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (br_valid && !stall) begin
                            br_resolved <= 1'b1;
                            br_taken    <= taken_c;
                        end else if (br_valid) begin
                            cond_q <= br_cond;
                            pol_q  <= br_polarity;
                            state  <= HOLD;
                        end
                    end
                    HOLD: begin
                        // ID is frozen while stalled, so br_valid is ignored here.
                        if (!stall) begin
                            br_resolved <= 1'b1;
                            br_taken    <= taken_c;
                            state       <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_flag_branch_unit.sv
// Directed bench for flag_branch_unit: flag capture, forwarding, stall/flush, reserved codes.
module tb_flag_branch_unit;

    logic        clk = 1'b0;
    logic        rst, stall, flush, flag_we, br_valid, br_polarity;
    logic [32:0] alu_res;
    logic [4:0]  flags;
    logic [2:0]  br_cond;
    logic [5:0]  flags_q;
    logic        br_resolved, br_taken;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    flag_branch_unit #(.DATA_WIDTH(32), .FLAG_WIDTH(5)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .alu_res(alu_res), .flags(flags), .flag_we(flag_we),
        .br_valid(br_valid), .br_polarity(br_polarity), .br_cond(br_cond),
        .flags_q(flags_q), .br_resolved(br_resolved), .br_taken(br_taken)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        stall = 0; flush = 0; flag_we = 0; br_valid = 0;
        br_polarity = 0; br_cond = 0; alu_res = '0; flags = '0;
    endtask

    initial begin
        idle_inputs();
        rst = 1;
        // Reset with random inputs for two cycles
        for (int i = 0; i < 2; i++) begin
            stall = 1'($urandom); flush = 1'($urandom); flag_we = 1'b1;
            br_valid = 1'b1; br_polarity = 1'($urandom); br_cond = 3'($urandom);
            alu_res = {1'b1, 32'($urandom)}; flags = 5'($urandom);
            step();
        end
        chk("rst_flags", 64'(flags_q), 64'h0);
        chk("rst_res", 64'(br_resolved), 64'h0);
        chk("rst_taken", 64'(br_taken), 64'h0);
        rst = 0;
        idle_inputs();

        // Flag capture
        alu_res = 33'h1_0000_0000; flags = 5'b00001; flag_we = 1;
        step();
        chk("cap_flags", 64'(flags_q), 64'h21);
        flag_we = 0; flags = 5'b11110; alu_res = '0;
        step();
        chk("cap_hold", 64'(flags_q), 64'h21);
        chk("cap_nores", 64'(br_resolved), 64'h0);

        // Forwarding: flags_q zero=0, same-cycle write of zero=1
        flag_we = 1; flags = 5'b00000; alu_res = '0;
        step();
        chk("fwd_pre", 64'(flags_q), 64'h0);
        flags = 5'b00001; br_valid = 1; br_cond = 0; br_polarity = 1;
        step();
        chk("fwd_res", 64'(br_resolved), 64'h1);
        chk("fwd_taken", 64'(br_taken), 64'h1);
        chk("fwd_flags", 64'(flags_q), 64'h01);
        idle_inputs();
        step();
        chk("fwd_pulse1", 64'(br_resolved), 64'h0);

        // Forwarding with flush
        flag_we = 1; flags = 5'b00000;
        step();
        flags = 5'b00001; br_valid = 1; br_cond = 0; br_polarity = 1; flush = 1;
        step();
        chk("fl_res", 64'(br_resolved), 64'h0);
        chk("fl_taken", 64'(br_taken), 64'h0);
        chk("fl_flags", 64'(flags_q), 64'h0);
        idle_inputs();

        // Stall hold: jf on carry, carry cleared on release
        flag_we = 1; alu_res = 33'h1_0000_0000; flags = 5'b00000;
        step();
        chk("st_carry", 64'(flags_q), 64'h20);
        flag_we = 0; alu_res = '0;
        br_valid = 1; br_cond = 5; br_polarity = 0; stall = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("st_wait%0d", i), 64'(br_resolved), 64'h0);
            br_cond = 0; br_polarity = 1;
        end
        stall = 0; flag_we = 1; alu_res = '0; flags = 5'b00000; br_valid = 0;
        step();
        chk("st_res", 64'(br_resolved), 64'h1);
        chk("st_taken", 64'(br_taken), 64'h1);
        chk("st_flags", 64'(flags_q), 64'h0);
        idle_inputs();
        step();
        chk("st_pulse1", 64'(br_resolved), 64'h0);

        // Flush in HOLD; stalled flag write must not commit
        br_valid = 1; br_cond = 5; br_polarity = 0; stall = 1;
        flag_we = 1; flags = 5'b11111; alu_res = 33'h1_0000_0000;
        step();
        chk("fh_noflag", 64'(flags_q), 64'h0);
        flag_we = 0; alu_res = '0; flags = '0;
        br_valid = 0; flush = 1;
        step();
        chk("fh_flush", 64'(br_resolved), 64'h0);
        flush = 0; stall = 0;
        step();
        chk("fh_nopulse", 64'(br_resolved), 64'h0);
        br_valid = 1; br_cond = 1; br_polarity = 1;
        step();
        chk("fh_idle_res", 64'(br_resolved), 64'h1);
        chk("fh_idle_taken", 64'(br_taken), 64'h0);
        idle_inputs();

        // Reset mid-HOLD discards the branch
        br_valid = 1; br_cond = 5; br_polarity = 0; stall = 1;
        step();
        rst = 1;
        step();
        rst = 0; idle_inputs();
        step();
        chk("rh_nopulse", 64'(br_resolved), 64'h0);

        // Reserved codes never take, even with jf
        br_valid = 1; br_cond = 7; br_polarity = 0;
        step();
        chk("rsv7_res", 64'(br_resolved), 64'h1);
        chk("rsv7_taken", 64'(br_taken), 64'h0);
        br_cond = 6;
        step();
        chk("rsv6_taken", 64'(br_taken), 64'h0);
        idle_inputs();
        step();

        // Back-to-back: jt neg (neg=1), then jt overflow (overflow=0)
        br_valid = 1; br_cond = 2; br_polarity = 1; flag_we = 1; flags = 5'b00100;
        step();
        chk("b2b_res0", 64'(br_resolved), 64'h1);
        chk("b2b_taken0", 64'(br_taken), 64'h1);
        flag_we = 0; flags = '0; br_cond = 3; br_polarity = 1;
        step();
        chk("b2b_res1", 64'(br_resolved), 64'h1);
        chk("b2b_taken1", 64'(br_taken), 64'h0);
        idle_inputs();
        step();
        chk("b2b_end", 64'(br_resolved), 64'h0);
        chk("b2b_end_taken", 64'(br_taken), 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
